// File: rtl/game_controller.sv
// Round-sequencing FSM for the memory-matrix game: start, solution display, guessing, win/lose.
// Define REVEAL_ON_LOSE_EN to show the full solution on the LED board after a lost round.
module game_controller #(
    parameter int DISPLAY_CYCLES = 100_000_000,
    parameter int MAX_MISSES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] solution,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic       load_board,
    output logic [7:0] board_led,
    output logic [7:0] found,
    output logic [3:0] misses_left,
    output logic       win,
    output logic       lose,
    output logic [2:0] state
);

    localparam int TW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_WAIT = 3'd1,
        DISPLAY    = 3'd2,
        PLAY       = 3'd3,
        CHECK      = 3'd4,
        WIN        = 3'd5,
        LOSE       = 3'd6,
        END_WAIT   = 3'd7
    } state_t;

    state_t          st;
    logic [TW-1:0]   timer;
    logic [7:0]      sol_q;
    logic [7:0]      g_q;

    logic            hit;
    logic [7:0]      found_n;
    logic [3:0]      misses_n;
    logic            guess_onehot;
    logic [7:0]      lose_led;

    assign state = st;

    // A hit can only add tiles that are part of the latched solution.
    always_comb begin
        hit          = |(g_q & sol_q);
        found_n      = found | (g_q & sol_q);
        misses_n     = misses_left;
        if (!hit && misses_left != 4'd0)
            misses_n = misses_left - 4'd1;
        guess_onehot = (guess != 8'd0) && ((guess & (guess - 8'd1)) == 8'd0);
`ifdef REVEAL_ON_LOSE_EN
        lose_led     = sol_q;
`else
        lose_led     = found_n;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            timer       <= '0;
            sol_q       <= 8'd0;
            g_q         <= 8'd0;
            found       <= 8'd0;
            misses_left <= 4'(MAX_MISSES);
            board_led   <= 8'd0;
            win         <= 1'b0;
            lose        <= 1'b0;
            load_board  <= 1'b0;
        end else begin
            load_board <= 1'b0;
            case (st)
                IDLE: begin
                    if (start)
                        st <= START_WAIT;
                end
                START_WAIT: begin
                    if (!start) begin
                        st          <= DISPLAY;
                        load_board  <= 1'b1;
                        timer       <= TW'(DISPLAY_CYCLES - 1);
                        found       <= 8'd0;
                        misses_left <= 4'(MAX_MISSES);
                        board_led   <= solution;
                    end
                end
                // Timer starts at DISPLAY_CYCLES-1, so the state lasts DISPLAY_CYCLES cycles.
                DISPLAY: begin
                    if (timer != '0) begin
                        timer     <= timer - TW'(1);
                        board_led <= solution;
                    end else begin
                        sol_q     <= solution;
                        board_led <= found;
                        if (solution == 8'd0) begin
                            st  <= WIN;
                            win <= 1'b1;
                        end else begin
                            st <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (guess_valid && guess_onehot) begin
                        g_q <= guess;
                        st  <= CHECK;
                    end
                end
                CHECK: begin
                    found       <= found_n;
                    misses_left <= misses_n;
                    if (misses_n == 4'd0) begin
                        st        <= LOSE;
                        lose      <= 1'b1;
                        board_led <= lose_led;
                    end else if (found_n == sol_q) begin
                        st        <= WIN;
                        win       <= 1'b1;
                        board_led <= found_n;
                    end else begin
                        st        <= PLAY;
                        board_led <= found_n;
                    end
                end
                WIN, LOSE: begin
                    if (start)
                        st <= END_WAIT;
                end
                END_WAIT: begin
                    if (!start) begin
                        st        <= IDLE;
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        board_led <= 8'd0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller with DISPLAY_CYCLES=4, MAX_MISSES=3.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] solution;
    logic [7:0] guess;
    logic       guess_valid;
    logic       load_board;
    logic [7:0] board_led;
    logic [7:0] found;
    logic [3:0] misses_left;
    logic       win;
    logic       lose;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

`ifdef REVEAL_ON_LOSE_EN
    localparam logic [7:0] LOSE_LED = 8'hA5;
`else
    localparam logic [7:0] LOSE_LED = 8'h01;
`endif

    game_controller #(.DISPLAY_CYCLES(4), .MAX_MISSES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .solution   (solution),
        .guess      (guess),
        .guess_valid(guess_valid),
        .load_board (load_board),
        .board_led  (board_led),
        .found      (found),
        .misses_left(misses_left),
        .win        (win),
        .lose       (lose),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [7:0] sol);
        solution = sol;
        start = 1'b1;
        step();
        checkOutput("start_wait_state", 32'(state), 32'd1);
        start = 1'b0;
        step();
        checkOutput("load_board_pulse", 32'(load_board), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step();
                checkOutput("load_board_low", 32'(load_board), 32'd0);
            end
            checkOutput("display_state", 32'(state), 32'd2);
            checkOutput("display_led", 32'(board_led), 32'(sol));
        end
        step();
    endtask

    task automatic applyStimulus(input logic [7:0] g);
        guess = g;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        guess = 8'd0;
        checkOutput("check_state", 32'(state), 32'd4);
        step();
    endtask

    task automatic finish_round();
        start = 1'b1;
        step();
        checkOutput("end_wait_state", 32'(state), 32'd7);
        start = 1'b0;
        step();
        checkOutput("idle_state", 32'(state), 32'd0);
        checkOutput("idle_win", 32'(win), 32'd0);
        checkOutput("idle_lose", 32'(lose), 32'd0);
        checkOutput("idle_led", 32'(board_led), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        solution = 8'h00;
        guess = 8'h00;
        guess_valid = 1'b0;
        #2 reset = 1'b0;
        #2;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_misses", 32'(misses_left), 32'd3);
        checkOutput("rst_led", 32'(board_led), 32'd0);
        checkOutput("rst_load", 32'(load_board), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        step();

        // Round A: display timing, one hit, then asynchronous reset mid-PLAY
        start_round(8'hA5);
        checkOutput("play_state", 32'(state), 32'd3);
        checkOutput("play_led", 32'(board_led), 32'd0);
        applyStimulus(8'h01);
        checkOutput("a_found", 32'(found), 32'h01);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_state", 32'(state), 32'd0);
        checkOutput("async_found", 32'(found), 32'd0);
        checkOutput("async_misses", 32'(misses_left), 32'd3);
        checkOutput("async_led", 32'(board_led), 32'd0);
        #2 reset = 1'b1;
        step();

        // Round B: four hits win the round
        start_round(8'hA5);
        applyStimulus(8'h01);
        checkOutput("b_found1", 32'(found), 32'h01);
        applyStimulus(8'h04);
        checkOutput("b_found2", 32'(found), 32'h05);
        applyStimulus(8'h20);
        checkOutput("b_found3", 32'(found), 32'h25);
        checkOutput("b_play", 32'(state), 32'd3);
        applyStimulus(8'h80);
        checkOutput("b_found4", 32'(found), 32'hA5);
        checkOutput("b_win_state", 32'(state), 32'd5);
        checkOutput("b_win", 32'(win), 32'd1);
        checkOutput("b_misses", 32'(misses_left), 32'd3);
        checkOutput("b_win_led", 32'(board_led), 32'hA5);
        finish_round();

        // Round C: ignored multi-hot, repeat hit, start held in PLAY, then three misses
        start_round(8'hA5);
        guess = 8'h03;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        checkOutput("c_multihot", 32'(state), 32'd3);
        applyStimulus(8'h01);
        checkOutput("c_found", 32'(found), 32'h01);
        applyStimulus(8'h01);
        checkOutput("c_repeat_found", 32'(found), 32'h01);
        checkOutput("c_repeat_misses", 32'(misses_left), 32'd3);
        start = 1'b1;
        step();
        checkOutput("c_start_ignored", 32'(state), 32'd3);
        start = 1'b0;
        applyStimulus(8'h02);
        checkOutput("c_miss1", 32'(misses_left), 32'd2);
        applyStimulus(8'h08);
        checkOutput("c_miss2", 32'(misses_left), 32'd1);
        checkOutput("c_miss2_state", 32'(state), 32'd3);
        applyStimulus(8'h10);
        checkOutput("c_miss3", 32'(misses_left), 32'd0);
        checkOutput("c_lose_state", 32'(state), 32'd6);
        checkOutput("c_lose", 32'(lose), 32'd1);
        checkOutput("c_win_low", 32'(win), 32'd0);
        checkOutput("c_lose_led", 32'(board_led), 32'(LOSE_LED));
        start = 1'b1;
        step();
        checkOutput("c_endwait_led", 32'(board_led), 32'(LOSE_LED));
        checkOutput("c_endwait_lose", 32'(lose), 32'd1);
        start = 1'b0;
        step();
        checkOutput("c_idle_state", 32'(state), 32'd0);
        checkOutput("c_idle_lose", 32'(lose), 32'd0);

        // Round D: empty solution wins straight out of DISPLAY
        start_round(8'h00);
        checkOutput("d_win_state", 32'(state), 32'd5);
        checkOutput("d_win", 32'(win), 32'd1);
        finish_round();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
